// File: rtl/psum_requant_pipe.sv
// Multi-lane partial-sum accumulator with a per-lane fixed-point requantizer
// and a credit-checked output FIFO. It sits between the MAC array and the
// output SRAM writer.

// One lane: saturating accumulator followed by a 3-register requant pipeline.
module psum_requant_lane #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init,
    input  logic                    acc_en,
    input  logic                    acc_first,
    input  logic signed [ACC_W-1:0] psum,
    input  logic signed [31:0]      mult,
    input  logic signed [7:0]       shift,
    input  logic signed [31:0]      offset,
    input  logic signed [OUT_W-1:0] act_min,
    input  logic signed [OUT_W-1:0] act_max,
    input  logic                    active,
    output logic                    sat,
    output logic [OUT_W-1:0]        y
);
    localparam logic signed [31:0]      I32_MIN = 32'sh8000_0000;
    localparam logic signed [31:0]      I32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc, acc_base, acc_sum;
    logic signed [ACC_W:0]   raw;
    logic signed [31:0]      x_s0, m_s0, a_c;
    logic signed [7:0]       sh_s0;
    logic [7:0]              ls_c, rs_c, rs_s1, rs_s2;
    logic signed [63:0]      prod_c, prod_s1, rnd_c, q_c;
    logic                    sat_mul_s1, up_c;
    logic signed [31:0]      h_c, h_s2, sh_c, r_c;
    logic [31:0]             mask_c, rem_c;
    logic [32:0]             thr_c;
    logic signed [33:0]      y_c;

    // Restart the sum on the first block; clip to the ACC_W signed range.
    always_comb begin
        acc_base = acc_first ? '0 : acc;
        raw      = {acc_base[ACC_W-1], acc_base} + {psum[ACC_W-1], psum};
        acc_sum  = raw[ACC_W-1:0];
        if (raw[ACC_W] != raw[ACC_W-1])
            acc_sum = raw[ACC_W] ? ACC_MIN : ACC_MAX;
        sat = acc_en & (raw[ACC_W] != raw[ACC_W-1]);
    end

    // S1 combinational: split the signed shift, pre-shift left, full product.
    always_comb begin
        ls_c   = (sh_s0 > 0) ? sh_s0 : 8'd0;
        rs_c   = (sh_s0 > 0) ? 8'd0 : -sh_s0;
        a_c    = x_s0 <<< ls_c;
        prod_c = a_c * m_s0;
    end

    // S2 combinational: doubling high-mul with round-half-away nudge.
    always_comb begin
        rnd_c = prod_s1 + ((prod_s1 >= 0) ? 64'sd1073741824 : -64'sd1073741823);
        q_c   = (rnd_c < 0) ? ((rnd_c + 64'sd2147483647) >>> 31) : (rnd_c >>> 31);
        h_c   = sat_mul_s1 ? I32_MAX : q_c[31:0];
    end

    // S3 combinational: rounding right shift, zero point, clamp.
    always_comb begin
        mask_c = (32'd1 << rs_s2) - 32'd1;
        rem_c  = h_s2 & mask_c;
        thr_c  = {1'b0, mask_c >> 1} + {32'd0, h_s2[31]};
        up_c   = {1'b0, rem_c} > thr_c;
        sh_c   = h_s2 >>> rs_s2;
        r_c    = sh_c + {31'd0, up_c};
        y_c    = r_c + offset;
        y      = y_c[OUT_W-1:0];
        if (y_c < act_min) y = act_min;
        if (y_c > act_max) y = act_max;
        if (!active)       y = '0;
    end

    // Accumulator and pipeline registers; data regs load every cycle, valids live in the top.
    always_ff @(posedge clk) begin
        if (!rst || init) begin
            acc        <= '0;
            x_s0       <= '0;
            m_s0       <= '0;
            sh_s0      <= '0;
            prod_s1    <= '0;
            sat_mul_s1 <= 1'b0;
            rs_s1      <= '0;
            h_s2       <= '0;
            rs_s2      <= '0;
        end else begin
            if (acc_en) acc <= acc_sum;
            x_s0       <= acc_sum;
            m_s0       <= mult;
            sh_s0      <= shift;
            prod_s1    <= prod_c;
            sat_mul_s1 <= (a_c == I32_MIN) && (m_s0 == I32_MIN);
            rs_s1      <= rs_c;
            h_s2       <= h_c;
            rs_s2      <= rs_s1;
        end
    end
endmodule

module psum_requant_pipe #(
    parameter int NUM_LANES  = 8,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BLK_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init,
    input  logic [BLK_W-1:0]             cfg_total_blocks,
    input  logic                         psum_valid_i,
    output logic                         psum_ready_o,
    input  logic [NUM_LANES*ACC_W-1:0]   psum_data_i,
    input  logic [3:0]                   psum_lane_cnt_i,
    input  logic [NUM_LANES*32-1:0]      quant_mult_i,
    input  logic [NUM_LANES*8-1:0]       quant_shift_i,
    input  logic [31:0]                  output_offset_i,
    input  logic [OUT_W-1:0]             act_min_i,
    input  logic [OUT_W-1:0]             act_max_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NUM_LANES*OUT_W-1:0]   out_data_o,
    output logic [NUM_LANES-1:0]         out_lane_mask_o,
    output logic                         err_overflow_o
);
    localparam int STAGES = 2;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    typedef struct packed {
        logic [NUM_LANES-1:0] mask;
        logic [31:0]          offset;
        logic [OUT_W-1:0]     act_min;
        logic [OUT_W-1:0]     act_max;
    } side_t;

    typedef struct packed {
        logic [NUM_LANES-1:0]            mask;
        logic [NUM_LANES-1:0][OUT_W-1:0] data;
    } fifo_ent_t;

    logic [BLK_W-1:0]                blk, blk_nxt, tot_q, tot_eff;
    logic [3:0]                      lane_q, lane_eff;
    logic [NUM_LANES-1:0]            mask_eff, lane_sat;
    logic                            first_blk, last_blk, accept, launch, push, pop, err_q;
    logic [STAGES:0]                 vld_pipe;
    side_t                           side_pipe [STAGES+1];
    logic [NUM_LANES-1:0][OUT_W-1:0] lane_y;
    fifo_ent_t                       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]                   wr_ptr, rd_ptr;
    logic [CW-1:0]                   fifo_cnt, inflight;

    // Credit: every in-flight tile already owns a FIFO slot, so ready needs no out_ready_i path.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= STAGES; i++) inflight = inflight + CW'(vld_pipe[i]);
        psum_ready_o = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    end

    // Tile control: config is live on the first block and held for the rest of the tile.
    always_comb begin
        first_blk = (blk == '0);
        tot_eff   = first_blk ? ((cfg_total_blocks == '0) ? BLK_W'(1) : cfg_total_blocks) : tot_q;
        lane_eff  = first_blk ? psum_lane_cnt_i : lane_q;
        blk_nxt   = blk + BLK_W'(1);
        last_blk  = (blk_nxt == tot_eff);
        accept    = psum_valid_i & psum_ready_o;
        launch    = accept & last_blk;
        for (int i = 0; i < NUM_LANES; i++) mask_eff[i] = (i < int'(lane_eff));
        push      = vld_pipe[STAGES];
        pop       = out_valid_o & out_ready_i;
    end

    // Block counter, captured tile config and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst || init) begin
            blk    <= '0;
            tot_q  <= '0;
            lane_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                blk <= last_blk ? '0 : blk_nxt;
                if (first_blk) begin
                    tot_q  <= tot_eff;
                    lane_q <= psum_lane_cnt_i;
                end
            end
            if (|lane_sat) err_q <= 1'b1;
        end
    end

    // Valid shift register plus shared per-tile side data travelling with the lanes.
    always_ff @(posedge clk) begin
        if (!rst || init) begin
            vld_pipe <= '0;
            for (int k = 0; k <= STAGES; k++) side_pipe[k] <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[STAGES-1:0], launch};
            side_pipe[0] <= '{mask: mask_eff, offset: output_offset_i,
                              act_min: act_min_i, act_max: act_max_i};
            for (int k = 1; k <= STAGES; k++) side_pipe[k] <= side_pipe[k-1];
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        psum_requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .init      (init),
            .acc_en    (accept),
            .acc_first (first_blk),
            .psum      (psum_data_i[g*ACC_W +: ACC_W]),
            .mult      (quant_mult_i[g*32 +: 32]),
            .shift     (quant_shift_i[g*8 +: 8]),
            .offset    (side_pipe[STAGES].offset),
            .act_min   (side_pipe[STAGES].act_min),
            .act_max   (side_pipe[STAGES].act_max),
            .active    (side_pipe[STAGES].mask[g]),
            .sat       (lane_sat[g]),
            .y         (lane_y[g])
        );
    end

    // Output FIFO; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || init) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem[k] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{mask: side_pipe[STAGES].mask, data: lane_y};
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign out_valid_o     = (fifo_cnt != '0);
    assign out_data_o      = out_valid_o ? fifo_mem[rd_ptr].data : '0;
    assign out_lane_mask_o = out_valid_o ? fifo_mem[rd_ptr].mask : '0;
    assign err_overflow_o  = err_q;
endmodule
